// File: rtl/pg_flr_port_sequencer.sv
// Per-port FLR sequencer: round-robin pick of pending ports, quiesce, drain, reset hold, completion.
// Optional drain timeout enabled by defining PG_FLR_DRAIN_TIMEOUT_EN.
module pg_flr_port_sequencer #(
    parameter int NUM_PORTS            = 4,
    parameter int RST_HOLD_CYCLES      = 16,
    parameter int DRAIN_TIMEOUT_CYCLES = 1024,
    parameter int IDX_W                = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] i_flr_req,
    input  logic [NUM_PORTS-1:0] i_port_tx_idle,
    input  logic [NUM_PORTS-1:0] i_rd_flush_done,
    input  logic                 i_afu_softreset,
    output logic [NUM_PORTS-1:0] o_port_quiesce,
    output logic [NUM_PORTS-1:0] o_port_rst_n,
    output logic                 o_flr_done_valid,
    output logic [IDX_W-1:0]     o_flr_done_port,
    output logic                 o_flr_done_timeout,
    input  logic                 i_flr_done_ready,
    output logic                 o_busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_HOLD, ST_RESP} state_t;

    localparam logic [7:0] HOLD_LAST = 8'(RST_HOLD_CYCLES - 1);

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       sel_q, sel_d, last_q, last_d;
    logic [NUM_PORTS-1:0]   pend_q, pend_d, pend_clr_s, sel_mask_s;
    logic [7:0]             hold_cnt_q, hold_cnt_d;
    logic [NUM_PORTS-1:0]   quiesce_q, quiesce_d, port_rst_n_q, port_rst_n_d;
    logic                   done_valid_q, done_valid_d, busy_q, busy_d;
    logic [IDX_W-1:0]       done_port_q, done_port_d;
    logic                   rr_found_s, drain_ok_s;
    logic [IDX_W-1:0]       rr_idx_s;

`ifdef PG_FLR_DRAIN_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(DRAIN_TIMEOUT_CYCLES - 1);
    logic [15:0]            to_cnt_q, to_cnt_d;
    logic                   to_flag_q, to_flag_d, done_timeout_q, done_timeout_d;
`else
    logic                   unused_cfg_s;
    assign unused_cfg_s = ^16'(DRAIN_TIMEOUT_CYCLES);
`endif

    // Port index reached by stepping 'off' places past 'base', wrapping at NUM_PORTS.
    function automatic logic [IDX_W-1:0] rr_wrap(input logic [IDX_W-1:0] base, input int off);
        int v;
        v = int'(base) + off;
        if (v >= NUM_PORTS) begin
            v = v - NUM_PORTS;
        end else begin
            v = v;
        end
        return IDX_W'(v);
    endfunction

    // Round-robin search for the first pending port after the last serviced one.
    always_comb begin
        rr_found_s = 1'b0;
        rr_idx_s   = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            if (!rr_found_s && pend_q[rr_wrap(last_q, i)]) begin
                rr_found_s = 1'b1;
                rr_idx_s   = rr_wrap(last_q, i);
            end else begin
                rr_found_s = rr_found_s;
            end
        end
    end

    assign drain_ok_s = i_port_tx_idle[sel_q] && i_rd_flush_done[sel_q];

    // Next-state logic; outputs are derived from the next state so they register in step with it.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;
        pend_clr_s = '0;
`ifdef PG_FLR_DRAIN_TIMEOUT_EN
        to_cnt_d   = to_cnt_q;
        to_flag_d  = to_flag_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (rr_found_s) begin
                    sel_d      = rr_idx_s;
                    pend_clr_s = NUM_PORTS'(1'b1) << rr_idx_s;
                    state_d    = ST_DRAIN;
`ifdef PG_FLR_DRAIN_TIMEOUT_EN
                    to_cnt_d   = 16'd0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (drain_ok_s) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = 8'd0;
`ifdef PG_FLR_DRAIN_TIMEOUT_EN
                    to_flag_d  = 1'b0;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = 8'd0;
                    to_flag_d  = 1'b1;
                end else begin
                    to_cnt_d   = to_cnt_q + 16'd1;
                end
`else
                end else begin
                    state_d = ST_DRAIN;
                end
`endif
            end
            ST_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = ST_RESP;
                    last_d  = sel_q;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            ST_RESP: begin
                if (done_valid_q && i_flr_done_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A request in the same cycle as selection re-arms the port for a later service.
        pend_d       = (pend_q & ~pend_clr_s) | i_flr_req;
        sel_mask_s   = NUM_PORTS'(1'b1) << sel_d;
        quiesce_d    = (state_d == ST_DRAIN || state_d == ST_HOLD) ? sel_mask_s : '0;
        port_rst_n_d = ~((state_d == ST_HOLD) ? sel_mask_s : '0) & ~{NUM_PORTS{i_afu_softreset}};
        done_valid_d = (state_d == ST_RESP);
        done_port_d  = (state_d == ST_RESP) ? sel_d : '0;
        busy_d       = (state_d != ST_IDLE);
`ifdef PG_FLR_DRAIN_TIMEOUT_EN
        done_timeout_d = (state_d == ST_RESP) ? to_flag_d : 1'b0;
`endif
    end

    // State, bookkeeping and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            sel_q        <= '0;
            last_q       <= IDX_W'(NUM_PORTS - 1);
            pend_q       <= '0;
            hold_cnt_q   <= 8'd0;
            quiesce_q    <= '0;
            port_rst_n_q <= '0;
            done_valid_q <= 1'b0;
            done_port_q  <= '0;
            busy_q       <= 1'b0;
`ifdef PG_FLR_DRAIN_TIMEOUT_EN
            to_cnt_q       <= 16'd0;
            to_flag_q      <= 1'b0;
            done_timeout_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            last_q       <= last_d;
            pend_q       <= pend_d;
            hold_cnt_q   <= hold_cnt_d;
            quiesce_q    <= quiesce_d;
            port_rst_n_q <= port_rst_n_d;
            done_valid_q <= done_valid_d;
            done_port_q  <= done_port_d;
            busy_q       <= busy_d;
`ifdef PG_FLR_DRAIN_TIMEOUT_EN
            to_cnt_q       <= to_cnt_d;
            to_flag_q      <= to_flag_d;
            done_timeout_q <= done_timeout_d;
`endif
        end
    end

    assign o_port_quiesce   = quiesce_q;
    assign o_port_rst_n     = port_rst_n_q;
    assign o_flr_done_valid = done_valid_q;
    assign o_flr_done_port  = done_port_q;
    assign o_busy           = busy_q;
`ifdef PG_FLR_DRAIN_TIMEOUT_EN
    assign o_flr_done_timeout = done_timeout_q;
`else
    assign o_flr_done_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pg_flr_port_sequencer.sv
// Directed self-checking bench for pg_flr_port_sequencer (NUM_PORTS=4, RST_HOLD_CYCLES=16).
module tb_pg_flr_port_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] flr_req, tx_idle, flush_done;
    logic       softreset, done_ready;
    logic [3:0] quiesce, port_rst_n;
    logic       done_valid, done_timeout, busy;
    logic [1:0] done_port;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pg_flr_port_sequencer #(
        .NUM_PORTS(4), .RST_HOLD_CYCLES(16), .DRAIN_TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_flr_req(flr_req), .i_port_tx_idle(tx_idle),
        .i_rd_flush_done(flush_done), .i_afu_softreset(softreset),
        .o_port_quiesce(quiesce), .o_port_rst_n(port_rst_n),
        .o_flr_done_valid(done_valid), .o_flr_done_port(done_port),
        .o_flr_done_timeout(done_timeout), .i_flr_done_ready(done_ready), .o_busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [3:0] m);
        flr_req = m;
        tick();
        flr_req = 4'b0000;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        n_vec++;
        if ({quiesce, port_rst_n, done_valid, done_port, done_timeout, busy} !== 13'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got q=%b r=%b v=%b p=%0d t=%b b=%b want all 0",
                     quiesce, port_rst_n, done_valid, done_port, done_timeout, busy);
        end
        rst_n = 1'b1;
        tick();
        n_vec++;
        if (port_rst_n !== 4'b1111 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: got rst_n=%b busy=%b want 1111 0", port_rst_n, busy);
        end
    endtask

    task automatic test_single();
        pulse(4'b0100);
        tick();
        n_vec++;
        if (quiesce !== 4'b0100 || port_rst_n !== 4'b1111 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL single_quiesce: got q=%b r=%b b=%b want 0100 1111 1", quiesce, port_rst_n, busy);
        end
        for (int k = 1; k <= 16; k++) begin
            tick();
            n_vec++;
            if (port_rst_n !== 4'b1011 || quiesce !== 4'b0100 || done_valid !== 1'b0) begin
                n_err++;
                $display("FAIL single_hold[%0d]: got r=%b q=%b v=%b want 1011 0100 0", k, port_rst_n, quiesce, done_valid);
            end
        end
        tick();
        n_vec++;
        if (done_valid !== 1'b1 || done_port !== 2'd2 || done_timeout !== 1'b0 ||
            port_rst_n !== 4'b1111 || quiesce !== 4'b0000) begin
            n_err++;
            $display("FAIL single_done: got v=%b p=%0d t=%b r=%b q=%b want 1 2 0 1111 0000",
                     done_valid, done_port, done_timeout, port_rst_n, quiesce);
        end
        tick();
        n_vec++;
        if (done_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL single_accept: got v=%b b=%b want 0 0", done_valid, busy);
        end
    endtask

    task automatic test_simultaneous();
        int order[4];
        int when[4];
        int n_done   = 0;
        bit injected = 1'b0;
        do_reset();
        pulse(4'b1011);
        for (int c = 0; c < 300 && n_done < 4; c++) begin
            tick();
            if (done_valid === 1'b1) begin
                order[n_done] = int'(done_port);
                when[n_done]  = c;
                n_done++;
            end
            if (!injected && port_rst_n[1] === 1'b0) begin
                pulse(4'b0001);
                injected = 1'b1;
            end
        end
        n_vec++;
        if (n_done !== 4) begin
            n_err++;
            $display("FAIL simul_count: got %0d completions want 4", n_done);
        end else begin
            n_vec++;
            if (order[0] !== 0 || order[1] !== 1 || order[2] !== 3 || order[3] !== 0) begin
                n_err++;
                $display("FAIL simul_order: got %0d %0d %0d %0d want 0 1 3 0", order[0], order[1], order[2], order[3]);
            end
            n_vec++;
            if (when[2] - when[1] !== 19) begin
                n_err++;
                $display("FAIL simul_b2b_gap: got %0d cycles want 19", when[2] - when[1]);
            end
        end
    endtask

    task automatic test_merge();
        int ports[4];
        int n_done = 0;
        tx_idle = 4'b1110;
        pulse(4'b0001);
        tick();
        pulse(4'b0010);
        tick();
        pulse(4'b0010);
        n_vec++;
        if (quiesce !== 4'b0001 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL merge_stall: got q=%b b=%b want 0001 1", quiesce, busy);
        end
        tx_idle = 4'b1111;
        for (int c = 0; c < 120; c++) begin
            tick();
            if (done_valid === 1'b1 && n_done < 4) begin
                ports[n_done] = int'(done_port);
                n_done++;
            end
        end
        n_vec++;
        if (n_done !== 2) begin
            n_err++;
            $display("FAIL merge_count: got %0d completions want 2", n_done);
        end else begin
            n_vec++;
            if (ports[0] !== 0 || ports[1] !== 1) begin
                n_err++;
                $display("FAIL merge_order: got %0d %0d want 0 1", ports[0], ports[1]);
            end
        end
    endtask

    task automatic test_drain_stall();
        bit seen = 1'b0;
        flush_done = 4'b1110;
        pulse(4'b0001);
`ifdef PG_FLR_DRAIN_TIMEOUT_EN
        for (int k = 0; k < 8; k++) begin
            tick();
            n_vec++;
            if (port_rst_n !== 4'b1111 || quiesce !== 4'b0001) begin
                n_err++;
                $display("FAIL stall_drain[%0d]: got r=%b q=%b want 1111 0001", k, port_rst_n, quiesce);
            end
        end
        tick();
        n_vec++;
        if (port_rst_n !== 4'b1110) begin
            n_err++;
            $display("FAIL stall_timeout_hold: got r=%b want 1110", port_rst_n);
        end
        repeat (16) tick();
        n_vec++;
        if (done_valid !== 1'b1 || done_port !== 2'd0 || done_timeout !== 1'b1) begin
            n_err++;
            $display("FAIL stall_timeout_done: got v=%b p=%0d t=%b want 1 0 1", done_valid, done_port, done_timeout);
        end
        flush_done = 4'b1111;
        tick();
`else
        repeat (60) begin
            tick();
            if (done_valid === 1'b1) seen = 1'b1;
        end
        n_vec++;
        if (seen !== 1'b0 || busy !== 1'b1 || quiesce !== 4'b0001 || port_rst_n !== 4'b1111) begin
            n_err++;
            $display("FAIL stall_wait: got seen=%b b=%b q=%b r=%b want 0 1 0001 1111", seen, busy, quiesce, port_rst_n);
        end
        flush_done = 4'b1111;
        for (int c = 0; c < 40 && !seen; c++) begin
            tick();
            if (done_valid === 1'b1) seen = 1'b1;
        end
        n_vec++;
        if (seen !== 1'b1 || done_port !== 2'd0 || done_timeout !== 1'b0) begin
            n_err++;
            $display("FAIL stall_release: got seen=%b p=%0d t=%b want 1 0 0", seen, done_port, done_timeout);
        end
        tick();
`endif
    endtask

    task automatic test_backpressure();
        bit seen = 1'b0;
        done_ready = 1'b0;
        pulse(4'b0100);
        for (int c = 0; c < 40 && !seen; c++) begin
            tick();
            if (done_valid === 1'b1) seen = 1'b1;
        end
        pulse(4'b1000);
        for (int k = 0; k < 5; k++) begin
            n_vec++;
            if (done_valid !== 1'b1 || done_port !== 2'd2 || done_timeout !== 1'b0 ||
                quiesce !== 4'b0000 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: got v=%b p=%0d t=%b q=%b b=%b want 1 2 0 0000 1",
                         k, done_valid, done_port, done_timeout, quiesce, busy);
            end
            tick();
        end
        done_ready = 1'b1;
        tick();
        n_vec++;
        if (done_valid !== 1'b0 || quiesce !== 4'b0000 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL bp_accept: got v=%b q=%b b=%b want 0 0000 0", done_valid, quiesce, busy);
        end
        tick();
        n_vec++;
        if (quiesce !== 4'b1000 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL bp_next_drain: got q=%b b=%b want 1000 1", quiesce, busy);
        end
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            tick();
            if (done_valid === 1'b1) seen = 1'b1;
        end
        n_vec++;
        if (seen !== 1'b1 || done_port !== 2'd3) begin
            n_err++;
            $display("FAIL bp_second: got seen=%b p=%0d want 1 3", seen, done_port);
        end
        tick();
    endtask

    task automatic test_reset_mid_hold();
        bit seen = 1'b0;
        pulse(4'b0010);
        for (int c = 0; c < 40 && port_rst_n[1] !== 1'b0; c++) tick();
        repeat (3) tick();
        pulse(4'b1000);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({quiesce, port_rst_n, done_valid, done_port, done_timeout, busy} !== 13'd0) begin
            n_err++;
            $display("FAIL midhold_reset: got q=%b r=%b v=%b p=%0d t=%b b=%b want all 0",
                     quiesce, port_rst_n, done_valid, done_port, done_timeout, busy);
        end
        rst_n = 1'b1;
        tick();
        n_vec++;
        if (port_rst_n !== 4'b1111) begin
            n_err++;
            $display("FAIL midhold_release: got r=%b want 1111", port_rst_n);
        end
        repeat (40) begin
            tick();
            if (done_valid === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        n_vec++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL midhold_no_done: got activity=%b want 0", seen);
        end
    endtask

    task automatic test_softreset();
        bit seen = 1'b0;
        softreset = 1'b1;
        tick();
        n_vec++;
        if (port_rst_n !== 4'b0000 || busy !== 1'b0 || quiesce !== 4'b0000) begin
            n_err++;
            $display("FAIL soft_idle: got r=%b b=%b q=%b want 0000 0 0000", port_rst_n, busy, quiesce);
        end
        pulse(4'b0100);
        tick();
        n_vec++;
        if (quiesce !== 4'b0100 || busy !== 1'b1 || port_rst_n !== 4'b0000) begin
            n_err++;
            $display("FAIL soft_fsm_runs: got q=%b b=%b r=%b want 0100 1 0000", quiesce, busy, port_rst_n);
        end
        softreset = 1'b0;
        tick();
        n_vec++;
        if (port_rst_n !== 4'b1011) begin
            n_err++;
            $display("FAIL soft_release: got r=%b want 1011", port_rst_n);
        end
        for (int c = 0; c < 30 && !seen; c++) begin
            tick();
            if (done_valid === 1'b1) seen = 1'b1;
        end
        n_vec++;
        if (seen !== 1'b1 || done_port !== 2'd2) begin
            n_err++;
            $display("FAIL soft_done: got seen=%b p=%0d want 1 2", seen, done_port);
        end
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        flr_req    = 4'b0000;
        tx_idle    = 4'b1111;
        flush_done = 4'b1111;
        softreset  = 1'b0;
        done_ready = 1'b1;
        test_reset();
        test_single();
        test_simultaneous();
        test_merge();
        test_drain_stall();
        test_backpressure();
        test_reset_mid_hold();
        test_softreset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pg_flr_port_sequencer.md
# pg_flr_port_sequencer

Per-port function-level-reset sequencer for the port gasket. Captures VF FLR requests for the PR-slot ports, services them one at a time in round-robin order, quiesces the selected port, waits for its traffic to drain, and holds that port's reset for a fixed interval. It then issues a completion handshake back to the FLR response path. It sits between the FLR reset manager and the per-port reset inputs of the PR slot, in the `clk` domain.

## Interface
- `NUM_PORTS`, default 4: number of PR-slot ports; legal range 1–16.
- `RST_HOLD_CYCLES`, default 16: cycles `o_port_rst_n[sel]` is held low; legal range 1–255.
- `DRAIN_TIMEOUT_CYCLES`, default 1024: drain wait limit, used only with timeout enabled; legal range 1–65535.
- `IDX_W`, default `$clog2(NUM_PORTS)`, minimum 1: port index width.

Ports:
- `clk`  in  1  the one clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `i_flr_req`  in  NUM_PORTS  one-cycle FLR request pulse per port.
- `i_port_tx_idle`  in  NUM_PORTS  port has no TX in flight.
- `i_rd_flush_done`  in  NUM_PORTS  port has no outstanding reads.
- `i_afu_softreset`  in  1  global soft reset; forces every port into reset.
- `o_port_quiesce`  out  NUM_PORTS  blocks new requests from the port.
- `o_port_rst_n`  out  NUM_PORTS  per-port reset, active low.
- `o_flr_done_valid`  out  1  completion valid.
- `o_flr_done_port`  out  IDX_W  port that completed.
- `o_flr_done_timeout`  out  1  drain timed out before reset was applied.
- `i_flr_done_ready`  in  1  completion accepted.
- `o_busy`  out  1  FSM not in IDLE.

## Operation
- Pending register `pend[NUM_PORTS]` sets on `i_flr_req[p]`. A request for a port that is already pending merges: one service, one completion.
- FSM states: IDLE, DRAIN, HOLD, RESP.
- **IDLE:** if `pend != 0`, select the first set bit at or after `last+1` (round-robin, wrapping mod NUM_PORTS). Latch it into `sel`, clear `pend[sel]`, go to DRAIN.
- **DRAIN:**
  - `o_port_quiesce[sel]=1`.
  - When `i_port_tx_idle[sel] && i_rd_flush_done[sel]`, go to HOLD with timeout flag 0.
  - Timeout counter as described under Configuration.
- **HOLD:**
  - `o_port_quiesce[sel]=1`, `o_port_rst_n[sel]=0` for exactly RST_HOLD_CYCLES cycles.
  - Then go to RESP and set `last=sel`.
- **RESP:**
  - `o_flr_done_valid=1`; `o_flr_done_port=sel` and `o_flr_done_timeout` stay stable until accepted.
  - On `valid && i_flr_done_ready`, go to IDLE.
- A new `i_flr_req[sel]` arriving during DRAIN, HOLD or RESP re-sets `pend[sel]`; the port is serviced again later.
- `i_afu_softreset=1` drives all `o_port_rst_n` low, registered. The FSM, pend, and quiesce continue unaffected.
- Reset values: all outputs 0 except `o_port_rst_n`, which is all 0 (ports in reset). `pend=0`, `last=NUM_PORTS-1`, state IDLE.
- Asserting `rst_n` mid-sequence aborts the sequence. No completion is issued for the aborted port, and pending requests are lost.

## Timing
- All outputs are registered.
- `i_flr_req` pulse at cycle t:
  - `pend` set at t+1.
  - DRAIN entered at t+2, with `o_port_quiesce[sel]` high at t+2.
- Drain condition sampled true at cycle d:
  - `o_port_rst_n[sel]` low during d+1 … d+RST_HOLD_CYCLES.
  - `o_port_quiesce` held through d+RST_HOLD_CYCLES.
  - `o_flr_done_valid` high from d+RST_HOLD_CYCLES+1.
- Best-case request-to-done latency is RST_HOLD_CYCLES+3 cycles.
- Completion accepted at cycle a: next selection is at a+1 and DRAIN is entered at a+2.
- `o_port_rst_n` goes high on the first `clk` edge after `rst_n` deasserts, unless `i_afu_softreset` is high.

## Configuration
- `PG_FLR_DRAIN_TIMEOUT_EN` defined:
  - A 16-bit counter clears on DRAIN entry and increments each DRAIN cycle.
  - When it reaches DRAIN_TIMEOUT_CYCLES-1 without the drain condition, the FSM goes to HOLD with `o_flr_done_timeout=1`.
  - If the drain condition and the limit occur in the same cycle, drain wins and timeout is 0.
- Not defined:
  - No counter; DRAIN waits indefinitely.
  - `o_flr_done_timeout` is tied to 0.

## Test plan
- **Single FLR:** port 2 pulse with idle inputs high, ready high.
  - Quiesce[2] high at t+2.
  - rst_n[2] low for 16 cycles.
  - done_valid with port=2, timeout=0 at t+19.
- **Simultaneous FLRs:** ports 0, 1, 3 pulse together, `last=3`.
  - Completions come in order 0, 1, 3.
  - Re-pulse port 0 during port 1's HOLD; port 0 is serviced again after port 3.
- **Merge:** port 1 pulsed twice while pending and not yet selected → exactly one completion.
- **Drain stall with `PG_FLR_DRAIN_TIMEOUT_EN`, DRAIN_TIMEOUT_CYCLES=8:** `i_rd_flush_done[0]` low.
  - HOLD is entered after 8 DRAIN cycles.
  - done_timeout=1.
  - Without the macro, no completion before drain is released.
- **Backpressure:** `i_flr_done_ready` low for 5 cycles → valid, port and timeout stable; no new DRAIN until accepted.
- **Reset and softreset:**
  - `rst_n` asserted mid-HOLD → all outputs at reset values immediately, no completion.
  - `i_afu_softreset` high in IDLE → all `o_port_rst_n` low the next cycle, FSM unaffected.
